// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
//==============================================================================
// Module      : pipe_ctrl_pkg (package)
// Description : Shared definitions for the pipeline hazard controller:
//               FSM state encoding, mul/div opcode encoding and the
//               hard-wired zero register number.
// Revision    : 1.0 - initial release
//==============================================================================
package pipe_ctrl_pkg;

   typedef enum logic [0:0] {
      ST_RUN     = 1'b0,
      ST_MD_BUSY = 1'b1
   } md_state_e;

   localparam logic       MD_OP_MUL = 1'b0;
   localparam logic       MD_OP_DIV = 1'b1;

   localparam logic [4:0] REG_ZERO  = 5'd0;

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
//==============================================================================
// Module      : pipeline_hazard_ctrl_if
// Description : Bundle between the decode/execute stages and the hazard
//               controller.
//   master : the pipeline side; drives the ID/EX hazard inputs and receives
//            the stall/flush controls.
//   slave  : the hazard controller.
// Ports (signals)
//   id_rs, id_rt, id_uses_rt          - operands of the instruction in ID
//   ex_mem_read, ex_write_register    - load info of the instruction in EX
//   branch_taken                      - branch/jump resolved taken in ID
//   md_start, md_op                   - mul/div launch (0 = mul, 1 = div)
//   pc_write, ifid_write, ifid_flush  - front-end controls
//   idex_bubble                       - zero ID/EX control fields
//   md_busy, md_done                  - mul/div status
//   perf_stall_cycles                 - stall cycle counter
// Revision    : 1.0 - initial release
//==============================================================================
interface pipeline_hazard_ctrl_if;

   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        id_uses_rt;
   logic        ex_mem_read;
   logic [4:0]  ex_write_register;
   logic        branch_taken;
   logic        md_start;
   logic        md_op;

   logic        pc_write;
   logic        ifid_write;
   logic        ifid_flush;
   logic        idex_bubble;
   logic        md_busy;
   logic        md_done;
   logic [31:0] perf_stall_cycles;

   modport master (
      output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_write_register,
             branch_taken, md_start, md_op,
      input  pc_write, ifid_write, ifid_flush, idex_bubble, md_busy, md_done,
             perf_stall_cycles
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_write_register,
             branch_taken, md_start, md_op,
      output pc_write, ifid_write, ifid_flush, idex_bubble, md_busy, md_done,
             perf_stall_cycles
   );

endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
`default_nettype none
//==============================================================================
// Module      : load_use_detect
// Description : Combinational load-use hazard detector. Flags when the load
//               in EX writes a register the instruction in ID reads. Writes
//               to $zero never create a dependency.
// Ports
//   ex_mem_read       in  1  instruction in EX is a load
//   ex_write_register in  5  destination of the instruction in EX
//   id_rs, id_rt      in  5  source fields of the instruction in ID
//   id_uses_rt        in  1  instruction in ID actually reads rt
//   lu                out 1  load-use hazard
// Revision    : 1.0 - initial release
//==============================================================================
module load_use_detect
   import pipe_ctrl_pkg::*;
(
   input  wire logic       ex_mem_read,
   input  wire logic [4:0] ex_write_register,
   input  wire logic [4:0] id_rs,
   input  wire logic [4:0] id_rt,
   input  wire logic       id_uses_rt,
   output logic            lu
);

   assign lu = ex_mem_read
            && (ex_write_register != REG_ZERO)
            && ((ex_write_register == id_rs)
                || (id_uses_rt && (ex_write_register == id_rt)));

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Hazard controller for a 5-stage MIPS pipeline. Stalls one
//               cycle on load-use, flushes IF/ID on a taken branch, and holds
//               the front end for the full latency of a multi-cycle mul/div.
// Ports
//   clk  in  system clock
//   rst  in  synchronous active-high reset
//   hz   slave modport of pipeline_hazard_ctrl_if (hazard inputs and
//        pc_write / ifid_write / ifid_flush / idex_bubble / md_busy /
//        md_done / perf_stall_cycles outputs)
// Parameters
//   MUL_CYCLES, DIV_CYCLES : total front-end stall (>= 2), including the
//                            md_start cycle
//   CNT_W                  : counter width, 2^CNT_W > max(MUL, DIV)
// Build option
//   STALL_PERF_CNT_EN : when defined, perf_stall_cycles counts cycles with
//                       pc_write low (saturating); otherwise tied to zero.
// Revision    : 1.0 - initial release
//==============================================================================
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 32,
   parameter int CNT_W      = 6
) (
   input  wire logic             clk,
   input  wire logic             rst,
   pipeline_hazard_ctrl_if.slave hz
);

   md_state_e        state, next_state;
   logic [CNT_W-1:0] cnt, next_cnt;
   logic             lu;

   logic pc_write, ifid_write, ifid_flush, idex_bubble, md_busy, md_done;

   load_use_detect u_load_use_detect (
      .ex_mem_read       (hz.ex_mem_read),
      .ex_write_register (hz.ex_write_register),
      .id_rs             (hz.id_rs),
      .id_rt             (hz.id_rt),
      .id_uses_rt        (hz.id_uses_rt),
      .lu                (lu)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_RUN;
         cnt   <= '0;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
      end
   end

   always_comb begin
      next_state  = state;
      next_cnt    = cnt;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      md_busy     = 1'b0;
      md_done     = 1'b0;

      if (rst) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         next_state  = ST_RUN;
         next_cnt    = '0;
      end else begin
         case (state)
            ST_RUN: begin
               if (hz.md_start) begin
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_bubble = 1'b1;
                  next_state  = ST_MD_BUSY;
                  // The md_start cycle and the cnt==0 cycle are both stall
                  // cycles, hence the -2.
                  next_cnt    = (hz.md_op == MD_OP_DIV) ? CNT_W'(DIV_CYCLES - 2)
                                                        : CNT_W'(MUL_CYCLES - 2);
               end else if (lu) begin
                  // One cycle suffices: the bubble replaces the load's
                  // dependant in EX, so the load is in MEM next cycle.
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_bubble = 1'b1;
               end else if (hz.branch_taken) begin
                  ifid_flush  = 1'b1;
               end
            end

            ST_MD_BUSY: begin
               // IF/ID is held, so any pending branch re-resolves afterwards.
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               idex_bubble = 1'b1;
               md_busy     = 1'b1;
               if (cnt != '0) begin
                  next_cnt = cnt - CNT_W'(1);
               end else begin
                  md_done    = 1'b1;
                  next_state = ST_RUN;
               end
            end

            default: begin
               next_state = ST_RUN;
               next_cnt   = '0;
            end
         endcase
      end
   end

   assign hz.pc_write    = pc_write;
   assign hz.ifid_write  = ifid_write;
   assign hz.ifid_flush  = ifid_flush;
   assign hz.idex_bubble = idex_bubble;
   assign hz.md_busy     = md_busy;
   assign hz.md_done     = md_done;

`ifdef STALL_PERF_CNT_EN
   logic [31:0] perf_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_cnt <= '0;
      end else if (!pc_write && (perf_cnt != 32'hFFFF_FFFF)) begin
         perf_cnt <= perf_cnt + 32'd1;
      end
   end

   assign hz.perf_stall_cycles = perf_cnt;
`else
   assign hz.perf_stall_cycles = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Directed self-checking bench for pipeline_hazard_ctrl with
//               default parameters (MUL_CYCLES=4, DIV_CYCLES=32). Honours
//               STALL_PERF_CNT_EN for the perf counter expectations.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_pipeline_hazard_ctrl;
   import pipe_ctrl_pkg::*;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   pipeline_hazard_ctrl_if hz_if ();

   pipeline_hazard_ctrl #(
      .MUL_CYCLES (4),
      .DIV_CYCLES (32),
      .CNT_W      (6)
   ) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz_if)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Inputs change 1 time unit after the rising edge; outputs are checked
   // on the falling edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      hz_if.id_rs             = 5'd0;
      hz_if.id_rt             = 5'd0;
      hz_if.id_uses_rt        = 1'b0;
      hz_if.ex_mem_read       = 1'b0;
      hz_if.ex_write_register = 5'd0;
      hz_if.branch_taken      = 1'b0;
      hz_if.md_start          = 1'b0;
      hz_if.md_op             = MD_OP_MUL;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      hz_if.md_start = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_tests++;
         if (hz_if.pc_write !== 1'b0 || hz_if.ifid_write !== 1'b0 ||
             hz_if.ifid_flush !== 1'b1 || hz_if.idex_bubble !== 1'b1 ||
             hz_if.md_busy !== 1'b0 || hz_if.md_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs cyc%0d: pc=%b ifw=%b fl=%b bub=%b busy=%b done=%b, want 0 0 1 1 0 0",
                     i, hz_if.pc_write, hz_if.ifid_write, hz_if.ifid_flush,
                     hz_if.idex_bubble, hz_if.md_busy, hz_if.md_done);
         end
         tick();
      end
      rst = 1'b0;
      hz_if.md_start = 1'b0;
      @(negedge clk);
      n_tests++;
      if (hz_if.pc_write !== 1'b1 || hz_if.idex_bubble !== 1'b0 ||
          hz_if.ifid_flush !== 1'b0 || hz_if.md_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: pc=%b bub=%b fl=%b busy=%b, want 1 0 0 0",
                  hz_if.pc_write, hz_if.idex_bubble, hz_if.ifid_flush, hz_if.md_busy);
      end
      n_tests++;
      if (hz_if.perf_stall_cycles !== 32'd0) begin
         n_fail++;
         $display("FAIL perf_after_reset: got %0d want 0", hz_if.perf_stall_cycles);
      end
      tick();
   endtask

   task automatic test_load_use();
      // Hazard on rs: one stall cycle, then the bubble sits in EX.
      hz_if.ex_mem_read = 1'b1; hz_if.ex_write_register = 5'd8; hz_if.id_rs = 5'd8;
      @(negedge clk);
      n_tests++;
      if (hz_if.pc_write !== 1'b0 || hz_if.ifid_write !== 1'b0 ||
          hz_if.idex_bubble !== 1'b1 || hz_if.ifid_flush !== 1'b0) begin
         n_fail++;
         $display("FAIL lu_rs_stall: pc=%b ifw=%b bub=%b fl=%b, want 0 0 1 0",
                  hz_if.pc_write, hz_if.ifid_write, hz_if.idex_bubble, hz_if.ifid_flush);
      end
      tick();
      hz_if.ex_mem_read = 1'b0; hz_if.ex_write_register = 5'd0;
      @(negedge clk);
      n_tests++;
      if (hz_if.pc_write !== 1'b1 || hz_if.idex_bubble !== 1'b0) begin
         n_fail++;
         $display("FAIL lu_one_cycle: pc=%b bub=%b, want 1 0", hz_if.pc_write, hz_if.idex_bubble);
      end
      tick();
      // Load into $zero never stalls.
      hz_if.ex_mem_read = 1'b1; hz_if.ex_write_register = 5'd0; hz_if.id_rs = 5'd0;
      @(negedge clk);
      n_tests++;
      if (hz_if.pc_write !== 1'b1 || hz_if.idex_bubble !== 1'b0) begin
         n_fail++;
         $display("FAIL lu_reg_zero: pc=%b bub=%b, want 1 0", hz_if.pc_write, hz_if.idex_bubble);
      end
      tick();
      // rt match without rt use: no stall; with rt use: stall.
      hz_if.ex_write_register = 5'd8; hz_if.id_rs = 5'd3; hz_if.id_rt = 5'd8;
      hz_if.id_uses_rt = 1'b0;
      @(negedge clk);
      n_tests++;
      if (hz_if.pc_write !== 1'b1 || hz_if.idex_bubble !== 1'b0) begin
         n_fail++;
         $display("FAIL lu_rt_unused: pc=%b bub=%b, want 1 0", hz_if.pc_write, hz_if.idex_bubble);
      end
      hz_if.id_uses_rt = 1'b1;
      #1;
      n_tests++;
      if (hz_if.pc_write !== 1'b0 || hz_if.idex_bubble !== 1'b1) begin
         n_fail++;
         $display("FAIL lu_rt_used: pc=%b bub=%b, want 0 1", hz_if.pc_write, hz_if.idex_bubble);
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_branch();
      hz_if.branch_taken = 1'b1;
      @(negedge clk);
      n_tests++;
      if (hz_if.ifid_flush !== 1'b1 || hz_if.pc_write !== 1'b1 ||
          hz_if.ifid_write !== 1'b1 || hz_if.idex_bubble !== 1'b0) begin
         n_fail++;
         $display("FAIL branch_flush: fl=%b pc=%b ifw=%b bub=%b, want 1 1 1 0",
                  hz_if.ifid_flush, hz_if.pc_write, hz_if.ifid_write, hz_if.idex_bubble);
      end
      tick();
      // Stall beats the flush.
      hz_if.ex_mem_read = 1'b1; hz_if.ex_write_register = 5'd9; hz_if.id_rs = 5'd9;
      @(negedge clk);
      n_tests++;
      if (hz_if.ifid_flush !== 1'b0 || hz_if.idex_bubble !== 1'b1 || hz_if.pc_write !== 1'b0) begin
         n_fail++;
         $display("FAIL branch_vs_lu: fl=%b bub=%b pc=%b, want 0 1 0",
                  hz_if.ifid_flush, hz_if.idex_bubble, hz_if.pc_write);
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_multiply();
      hz_if.md_start = 1'b1; hz_if.md_op = MD_OP_MUL;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         n_tests++;
         if (hz_if.pc_write !== 1'b0 || hz_if.md_busy !== (c >= 2) ||
             hz_if.md_done !== (c == 4) || hz_if.idex_bubble !== 1'b1) begin
            n_fail++;
            $display("FAIL mul_cycle%0d: pc=%b busy=%b done=%b bub=%b, want 0 %b %b 1",
                     c, hz_if.pc_write, hz_if.md_busy, hz_if.md_done, hz_if.idex_bubble,
                     (c >= 2), (c == 4));
         end
         tick();
         hz_if.md_start = 1'b0;
      end
      @(negedge clk);
      n_tests++;
      if (hz_if.pc_write !== 1'b1 || hz_if.md_busy !== 1'b0 || hz_if.md_done !== 1'b0) begin
         n_fail++;
         $display("FAIL mul_return: pc=%b busy=%b done=%b, want 1 0 0",
                  hz_if.pc_write, hz_if.md_busy, hz_if.md_done);
      end
      tick();
   endtask

   // Runs a divide; when 'pulse' is set, md_start/lu/branch are asserted at
   // stall cycle 6 and must have no effect.
   task automatic run_divide(input bit pulse, input string tag);
      int cycles = 0;
      int dones  = 0;
      bit back   = 1'b0;
      hz_if.md_start = 1'b1; hz_if.md_op = MD_OP_DIV;
      for (int c = 1; c <= 100 && !back; c++) begin
         if (pulse && c == 6) begin
            hz_if.md_start = 1'b1; hz_if.md_op = MD_OP_MUL; hz_if.branch_taken = 1'b1;
            hz_if.ex_mem_read = 1'b1; hz_if.ex_write_register = 5'd8; hz_if.id_rs = 5'd8;
         end
         @(negedge clk);
         if (hz_if.pc_write === 1'b1) begin
            back = 1'b1;
         end else begin
            cycles++;
            if (hz_if.md_done === 1'b1) dones++;
            if (pulse && c == 6) begin
               n_tests++;
               if (hz_if.ifid_flush !== 1'b0 || hz_if.md_busy !== 1'b1 || hz_if.idex_bubble !== 1'b1) begin
                  n_fail++;
                  $display("FAIL ignored_inputs: fl=%b busy=%b bub=%b, want 0 1 1",
                           hz_if.ifid_flush, hz_if.md_busy, hz_if.idex_bubble);
               end
            end
            tick();
            idle_inputs();
         end
      end
      n_tests++;
      if (cycles != 32 || dones != 1) begin
         n_fail++;
         $display("FAIL %s: stall_cycles=%0d md_done_pulses=%0d, want 32 1", tag, cycles, dones);
      end
      tick();
   endtask

   task automatic test_divide();
      run_divide(1'b0, "div_length");
   endtask

   task automatic test_ignored_inputs();
      run_divide(1'b1, "div_ignored_length");
   endtask

   task automatic test_reset_mid_divide();
      int dones = 0;
      int stalls = 0;
      hz_if.md_start = 1'b1; hz_if.md_op = MD_OP_DIV;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         if (hz_if.md_done === 1'b1) dones++;
         tick();
         hz_if.md_start = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      n_tests++;
      if (hz_if.md_busy !== 1'b0 || hz_if.md_done !== 1'b0 ||
          hz_if.pc_write !== 1'b0 || hz_if.ifid_flush !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_div: busy=%b done=%b pc=%b fl=%b, want 0 0 0 1",
                  hz_if.md_busy, hz_if.md_done, hz_if.pc_write, hz_if.ifid_flush);
      end
      tick();
      rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if (hz_if.pc_write !== 1'b1 || hz_if.md_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_div_release: pc=%b busy=%b, want 1 0",
                  hz_if.pc_write, hz_if.md_busy);
      end
      n_tests++;
      if (hz_if.perf_stall_cycles !== 32'd0) begin
         n_fail++;
         $display("FAIL perf_cleared: got %0d want 0", hz_if.perf_stall_cycles);
      end
      tick();
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (hz_if.md_done === 1'b1) dones++;
         if (hz_if.pc_write !== 1'b1) stalls++;
         tick();
      end
      n_tests++;
      if (dones != 0 || stalls != 0) begin
         n_fail++;
         $display("FAIL reset_abort: md_done_pulses=%0d stalls=%0d, want 0 0", dones, stalls);
      end
   endtask

   task automatic test_perf_counter();
      hz_if.md_start = 1'b1; hz_if.md_op = MD_OP_MUL;
      tick();
      hz_if.md_start = 1'b0;
      repeat (5) tick();
      @(negedge clk);
      n_tests++;
`ifdef STALL_PERF_CNT_EN
      if (hz_if.perf_stall_cycles !== 32'd4) begin
         n_fail++;
         $display("FAIL perf_mul: got %0d want 4", hz_if.perf_stall_cycles);
      end
`else
      if (hz_if.perf_stall_cycles !== 32'd0) begin
         n_fail++;
         $display("FAIL perf_disabled: got %0d want 0", hz_if.perf_stall_cycles);
      end
`endif
      tick();
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b1;
      idle_inputs();
      test_reset();
      test_load_use();
      test_branch();
      test_multiply();
      test_divide();
      test_ignored_inputs();
      test_reset_mid_divide();
      test_perf_counter();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
